// File: rtl/downstream_chan_arbiter_pkg.sv
// Shared types and defaults for the downstream channel arbiter and its picker.
package downstream_pkg;

    localparam int NUM_CH_DEF      = 4;
    localparam int DATA_W_DEF      = 32;
    localparam int TOKEN_BATCH_DEF = 4;

    // Channel-index width; a single channel still needs one bit to carry an index.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int CH_W_DEF = ch_width(NUM_CH_DEF);

    typedef logic [CH_W_DEF-1:0] ch_idx_t;

    // The output slot either holds a word for the core or it does not.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/downstream_chan_arbiter_if.sv
// Channel-side and core-side signals of the arbiter bundled as one interface.
// master: the arbiter itself; slave: the surrounding channels and core consumer.
interface downstream_chan_arbiter_if
    import downstream_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH_W   = ch_width(NUM_CH)
);

    logic [NUM_CH-1:0]        ch_valid_i;
    logic [NUM_CH*DATA_W-1:0] ch_data_i;
    logic [NUM_CH-1:0]        ch_mask_i;
    logic [NUM_CH-1:0]        ch_ready_o;
    logic                     core_valid_o;
    logic [DATA_W-1:0]        core_data_o;
    logic [CH_W-1:0]          core_ch_o;
    logic                     core_ready_i;
    logic [NUM_CH-1:0]        token_o;

    modport master (
        input  ch_valid_i,
        input  ch_data_i,
        input  ch_mask_i,
        input  core_ready_i,
        output ch_ready_o,
        output core_valid_o,
        output core_data_o,
        output core_ch_o,
        output token_o
    );

    modport slave (
        output ch_valid_i,
        output ch_data_i,
        output ch_mask_i,
        output core_ready_i,
        input  ch_ready_o,
        input  core_valid_o,
        input  core_data_o,
        input  core_ch_o,
        input  token_o
    );

endinterface

// File: rtl/downstream_rr_pick.sv
// Combinational rotating-priority picker: the first eligible requester at or
// above rr_ptr_i (wrapping past the top) wins. Shared with the upstream scheduler.
module downstream_rr_pick
    import downstream_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] eligible_i,
    input  logic [CH_W-1:0]   rr_ptr_i,
    output logic [NUM_CH-1:0] grant_o,
    output logic [CH_W-1:0]   grant_idx_o,
    output logic              any_grant_o
);

    // One extra bit so the pointer-plus-offset sum cannot overflow before the wrap.
    logic [CH_W:0] cand;

    // Walk the channels in priority order starting at the pointer; the first hit sticks.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_grant_o = 1'b0;
        cand        = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = {1'b0, rr_ptr_i} + (CH_W+1)'(i);
            if (cand >= (CH_W+1)'(NUM_CH)) begin
                cand = cand - (CH_W+1)'(NUM_CH);
            end
            if (!any_grant_o && eligible_i[cand[CH_W-1:0]]) begin
                any_grant_o               = 1'b1;
                grant_idx_o               = cand[CH_W-1:0];
                grant_o[cand[CH_W-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/downstream_chan_arbiter.sv
// Round-robin arbiter sharing one registered core-side slot between NUM_CH
// downstream channels, with per-channel credit tokens counted at core drain.
module downstream_chan_arbiter
    import downstream_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TOKEN_BATCH = TOKEN_BATCH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    downstream_chan_arbiter_if.master  bus
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int CNT_W = $clog2(TOKEN_BATCH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOKEN_BATCH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [NUM_CH-1:0] token_q, token_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];

    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] pick_grant;
    logic [CH_W-1:0]   pick_idx;
    logic              pick_any;
    logic              slot_valid;
    logic              slot_free;
    logic              drain;
    logic              accept;

    assign eligible   = bus.ch_valid_i & bus.ch_mask_i;
    assign slot_valid = (state_q == FULL);
    assign slot_free  = !slot_valid | bus.core_ready_i;
    assign drain      = slot_valid & bus.core_ready_i;
    // Reset gating keeps the accept strobe quiet while rst is held, so no
    // channel believes a word was taken during reset.
    assign accept     = slot_free & pick_any & !rst;

    downstream_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_pick (
        .eligible_i  (eligible),
        .rr_ptr_i    (rr_ptr_q),
        .grant_o     (pick_grant),
        .grant_idx_o (pick_idx),
        .any_grant_o (pick_any)
    );

    // Slot state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot next state: fills on accept, empties only when drained with no refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   state_d = accept ? FULL : EMPTY;
            FULL:    state_d = (drain && !accept) ? EMPTY : FULL;
            default: state_d = EMPTY;
        endcase
    end

    // Outputs: slot contents, tokens, and the one-hot accept strobe to the channels.
    always_comb begin
        bus.core_valid_o = slot_valid;
        bus.core_data_o  = data_q;
        bus.core_ch_o    = ch_q;
        bus.token_o      = token_q;
        bus.ch_ready_o   = accept ? pick_grant : '0;
    end

    // Slot payload and pointer: load the granted word and advance past the winner.
    always_comb begin
        data_d   = data_q;
        ch_d     = ch_q;
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            data_d   = bus.ch_data_i[int'(pick_idx)*DATA_W +: DATA_W];
            ch_d     = pick_idx;
            rr_ptr_d = (pick_idx == CH_LAST) ? '0 : pick_idx + 1'b1;
        end
    end

    // Credit counters advance when the core actually takes a word, not at grant.
    always_comb begin
        token_d = token_q;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k];
            if (drain && (ch_q == CH_W'(k))) begin
                if (cnt_q[k] == CNT_LAST) begin
                    cnt_d[k]   = '0;
                    token_d[k] = ~token_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Datapath registers; reset discards any word held in the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            ch_q     <= '0;
            rr_ptr_q <= '0;
            token_q  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            data_q   <= data_d;
            ch_q     <= ch_d;
            rr_ptr_q <= rr_ptr_d;
            token_q  <= token_d;
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

endmodule

// File: tb/tb_downstream_chan_arbiter.sv
// Scoreboard bench for downstream_chan_arbiter: a 4-channel instance covers
// ordering, tokens, stalls, masking and reset; a 3-channel instance covers wrap.
module tb_downstream_chan_arbiter;
    import downstream_pkg::*;

    typedef struct {
        logic [31:0] data;
        ch_idx_t     ch;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int passCnt  = 0;
    int totalCnt = 0;
    exp_t sbQ[$];

    downstream_chan_arbiter_if #(.NUM_CH(4), .DATA_W(32)) bus ();
    downstream_chan_arbiter_if #(.NUM_CH(3), .DATA_W(32)) bus3 ();

    downstream_chan_arbiter #(.NUM_CH(4), .DATA_W(32), .TOKEN_BATCH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    downstream_chan_arbiter #(.NUM_CH(3), .DATA_W(32), .TOKEN_BATCH(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3.master)
    );

    // Free-running core clock.
    always #5 clk = ~clk;

    // Every comparison funnels through here so pass/total counts stay honest.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        totalCnt++;
        if (actual === expected) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] mask,
                                 input logic ready, input logic [127:0] data);
        bus.ch_valid_i   = valid;
        bus.ch_mask_i    = mask;
        bus.core_ready_i = ready;
        bus.ch_data_i    = data;
    endtask

    task automatic expectWord(input logic [31:0] data, input int ch);
        exp_t e;
        e.data = data;
        e.ch   = ch_idx_t'(ch);
        sbQ.push_back(e);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [63:0] oneHot(input int k);
        logic [63:0] v;
        v = 64'd1 << k;
        return v;
    endfunction

    // Scoreboard side: every word the core takes must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.core_valid_o && bus.core_ready_i) begin
            if (sbQ.size() == 0) begin
                checkOutput("sb_underflow", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sbQ.pop_front();
                checkOutput("sb_data", 64'(bus.core_data_o), 64'(e.data));
                checkOutput("sb_ch", 64'(bus.core_ch_o), 64'(e.ch));
            end
        end
    end

    // Watchdog so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int drains;
        applyStimulus(4'b1111, 4'b1111, 1'b1, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
        bus3.ch_valid_i   = '0;
        bus3.ch_mask_i    = '0;
        bus3.core_ready_i = 1'b0;
        bus3.ch_data_i    = '0;

        // Reset values, with requests present so ch_ready_o must be held low.
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 64'(bus.ch_ready_o), 64'd0);
        checkOutput("rst_valid", 64'(bus.core_valid_o), 64'd0);
        checkOutput("rst_data", 64'(bus.core_data_o), 64'd0);
        checkOutput("rst_ch", 64'(bus.core_ch_o), 64'd0);
        checkOutput("rst_token", 64'(bus.token_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] round-robin ordering, all channels valid");
        for (int i = 0; i < 5; i++) begin
            expectWord(32'hA0 + 32'(i % 4), i % 4);
            @(negedge clk);
            checkOutput("rr_ready", 64'(bus.ch_ready_o), oneHot(i % 4));
            nextCycle();
        end
        bus.ch_valid_i = '0;
        repeat (3) nextCycle();

        $display("[TB] single channel, token toggling");
        applyStimulus(4'b0100, 4'b1111, 1'b1, {4{32'h1234_5678}});
        resetDut();
        for (int i = 0; i < 10; i++) begin
            if (i < 8) expectWord(32'h1234_5678, 2);
            @(negedge clk);
            checkOutput("tok_ready", 64'(bus.ch_ready_o), (i < 8) ? 64'h4 : 64'h0);
            drains = (i < 1) ? 0 : ((i - 1 > 8) ? 8 : i - 1);
            checkOutput("tok_token", 64'(bus.token_o), (((drains / 4) % 2) == 1) ? 64'h4 : 64'h0);
            nextCycle();
            if (i == 7) bus.ch_valid_i = '0;
        end

        $display("[TB] core stall holds the slot");
        applyStimulus(4'b0010, 4'b1111, 1'b0, {32'h33, 32'h22, 32'hDEAD_BEEF, 32'h10});
        resetDut();
        expectWord(32'hDEAD_BEEF, 1);
        @(negedge clk);
        checkOutput("stall_first", 64'(bus.ch_ready_o), 64'h2);
        nextCycle();
        applyStimulus(4'b1111, 4'b1111, 1'b0, {32'h33, 32'h22, 32'h11, 32'h10});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_ready", 64'(bus.ch_ready_o), 64'h0);
            checkOutput("stall_valid", 64'(bus.core_valid_o), 64'h1);
            checkOutput("stall_data", 64'(bus.core_data_o), 64'hDEAD_BEEF);
            checkOutput("stall_ch", 64'(bus.core_ch_o), 64'h1);
            nextCycle();
        end
        bus.core_ready_i = 1'b1;
        expectWord(32'h22, 2);
        @(negedge clk);
        checkOutput("stall_release", 64'(bus.ch_ready_o), 64'h4);
        nextCycle();
        bus.ch_valid_i = '0;
        repeat (2) nextCycle();

        $display("[TB] masking");
        applyStimulus(4'b1111, 4'b1010, 1'b1, {32'hB3, 32'hB2, 32'hB1, 32'hB0});
        resetDut();
        for (int i = 0; i < 5; i++) begin
            expectWord((i % 2 == 0) ? 32'hB1 : 32'hB3, (i % 2 == 0) ? 1 : 3);
            @(negedge clk);
            checkOutput("mask_ready", 64'(bus.ch_ready_o), (i % 2 == 0) ? 64'h2 : 64'h8);
            nextCycle();
        end
        bus.ch_mask_i    = 4'b1000;
        bus.core_ready_i = 1'b0;
        @(negedge clk);
        checkOutput("mask_hold_ready", 64'(bus.ch_ready_o), 64'h0);
        checkOutput("mask_hold_valid", 64'(bus.core_valid_o), 64'h1);
        checkOutput("mask_hold_ch", 64'(bus.core_ch_o), 64'h1);
        nextCycle();
        bus.core_ready_i = 1'b1;
        expectWord(32'hB3, 3);
        @(negedge clk);
        checkOutput("mask_release", 64'(bus.ch_ready_o), 64'h8);
        nextCycle();
        bus.ch_valid_i = '0;
        repeat (2) nextCycle();

        $display("[TB] reset while full");
        applyStimulus(4'b0001, 4'b1111, 1'b1, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        resetDut();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) expectWord(32'hC0, 0);
            nextCycle();
        end
        applyStimulus(4'b1111, 4'b1111, 1'b0, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
        checkOutput("pre_rst_valid", 64'(bus.core_valid_o), 64'h1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_valid", 64'(bus.core_valid_o), 64'h0);
        checkOutput("midrst_data", 64'(bus.core_data_o), 64'h0);
        checkOutput("midrst_token", 64'(bus.token_o), 64'h0);
        checkOutput("midrst_ready", 64'(bus.ch_ready_o), 64'h0);
        bus.core_ready_i = 1'b1;
        resetDut();
        for (int i = 0; i < 7; i++) begin
            if (i < 4) expectWord(32'hC0, 0);
            @(negedge clk);
            if (i == 0) checkOutput("postrst_first", 64'(bus.ch_ready_o), 64'h1);
            drains = (i < 1) ? 0 : ((i - 1 > 4) ? 4 : i - 1);
            checkOutput("postrst_token", 64'(bus.token_o), (drains >= 4) ? 64'h1 : 64'h0);
            nextCycle();
            if (i == 0) bus.ch_valid_i = 4'b0001;
            if (i == 3) bus.ch_valid_i = '0;
        end

        $display("[TB] three-channel wrap");
        bus3.ch_valid_i   = 3'b111;
        bus3.ch_mask_i    = 3'b111;
        bus3.core_ready_i = 1'b1;
        bus3.ch_data_i    = {32'h52, 32'h51, 32'h50};
        resetDut();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("wrap3_ready", 64'(bus3.ch_ready_o), oneHot(i % 3));
            if (i > 0) checkOutput("wrap3_ch", 64'(bus3.core_ch_o), 64'((i - 1) % 3));
            nextCycle();
        end
        bus3.ch_valid_i = '0;
        repeat (2) nextCycle();

        checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/downstream_chan_arbiter.md
# downstream_chan_arbiter

Round-robin arbiter that shares one core-side output port between `NUM_CH` downstream link channels. Each channel presents fully assembled 32-bit words, which each downstream channel builds from two 16-bit buffer halves. The arbiter registers the granted word in a one-entry output slot and returns per-channel credit to the I/O side as a toggling token. It sits between the downstream channel instances and the core consumer, in the core clock domain.

## Interface
Parameters:
- `NUM_CH`, 4: number of downstream channels; legal range 2..8.
- `DATA_W`, 32: word width.
- `TOKEN_BATCH`, 4: words delivered per token toggle; power of two, 1..16.

Ports (single clock; reset is asynchronous and active-high):
- `clk` input 1: clock.
- `rst` input 1: asynchronous active-high reset.
- `ch_valid_i` input NUM_CH: per-channel word available.
- `ch_data_i` input NUM_CH*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
- `ch_mask_i` input NUM_CH: 1 = channel enabled for arbitration.
- `ch_ready_o` output NUM_CH: one-hot-or-zero accept strobe.
- `core_valid_o` output 1: output slot holds a word.
- `core_data_o` output DATA_W: slot word.
- `core_ch_o` output CH_W: source channel of slot word, where CH_W = max(1, clog2(NUM_CH)).
- `core_ready_i` input 1: core accepts slot word.
- `token_o` output NUM_CH: per-channel credit toggle.

## Operation
- Slot FSM with two states:
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on drain without accept.
  - FULL -> FULL on drain with accept, or when the core stalls.
- Drain is defined as `core_valid_o & core_ready_i`.
- `slot_free = !core_valid_o | core_ready_i`.
- Eligible channels are `ch_valid_i & ch_mask_i`.
- When `slot_free` and at least one channel is eligible, the first eligible channel found searching upward from `rr_ptr` (with wrap) is granted. Its `ch_ready_o` bit is high that cycle, combinationally.
- On a grant, the slot loads that channel's data and index. `rr_ptr` then moves to the granted index + 1, wrapping to 0 after NUM_CH-1.
- When there is no grant, `rr_ptr` holds.
- `ch_ready_o` never asserts for a masked channel, a non-valid channel, or while the slot is held by a stall.
- Masking a channel whose word is already in the slot does not cancel it; that word is still delivered.
- Token counters:
  - Each channel has a counter of width clog2(TOKEN_BATCH)+1, incremented on drain of a word with `core_ch_o == k`.
  - When the counter reaches TOKEN_BATCH-1 and increments, it wraps to 0 and `token_o[k]` toggles.
  - Tokens are counted at core drain, not at grant.

## Timing
- Reset values: `core_valid_o`=0, `core_data_o`=0, `core_ch_o`=0, `token_o`=0, `rr_ptr`=0, all token counters 0, FSM=EMPTY.
- `ch_ready_o` is combinational and is 0 while `rst` is asserted.
- Latency: a word accepted in cycle N is on `core_valid_o`/`core_data_o` in cycle N+1.
- Throughput: with `core_ready_i` held high, one word per cycle.
- `core_data_o` and `core_ch_o` stay stable while `core_valid_o & !core_ready_i`.
- `token_o[k]` toggles in the cycle after the TOKEN_BATCH-th drain from channel k.
- Simultaneous drain of a word from channel k and a grant to channel k are both handled in the same edge.
- Reset mid-operation: the slot word is discarded and counters clear. Upstream channels must not treat a dropped word as consumed.

## Structure
- Package `downstream_pkg` holds:
  - the `ch_idx_t` typedef of width CH_W;
  - the `slot_state_e` enum (EMPTY, FULL);
  - the default constants NUM_CH_DEF=4, DATA_W_DEF=32, TOKEN_BATCH_DEF=4.
- Sub-module `downstream_rr_pick` is the combinational rotating-priority picker:
  - inputs: eligible vector, `rr_ptr`;
  - outputs: one-hot grant, grant index, any-grant.
  - It is reused by the upstream scheduler.

## Test plan
- Reset, then ch 0..3 all valid with data 0xA0..0xA3 and `core_ready_i`=1: output sequence 0xA0, 0xA1, 0xA2, 0xA3, 0xA0, one word per cycle, `core_ch_o` 0, 1, 2, 3, 0.
- Only ch2 valid with a constant word, ready high for 8 cycles: ch2 is granted every cycle and `token_o[2]` toggles after the 4th and 8th drains, with `token_o` = 4'b0100 then 4'b0000.
- Slot holding 0xDEAD_BEEF from ch1, `core_ready_i`=0 for 5 cycles with all channels valid: `ch_ready_o`=0 and the output is stable throughout. On release, 0xDEAD_BEEF drains and ch2 is granted in the same cycle.
- `ch_mask_i`=4'b1010 with all channels valid: only ch1 and ch3 alternate. Clearing mask bit 1 while ch1's word is in the slot still delivers that word.
- Assert `rst` while FULL with token counter 3 on ch0: `core_valid_o` drops immediately and `token_o` and counters are 0. After release, the first grant goes to ch0.
- NUM_CH=3: grants wrap 0→1→2→0, with `rr_ptr` never reaching 3.
